// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lif_pkg
//  Purpose  : Shared opcodes, FSM state type and reset values for the LIF layer.
//  Revision : 1.0  initial release
// ============================================================================
package lif_pkg;

    localparam logic [2:0] OP_INPUTS    = 3'b000;
    localparam logic [2:0] OP_WEIGHTS   = 3'b001;
    localparam logic [2:0] OP_THRESHOLD = 3'b010;
    localparam logic [2:0] OP_SHIFT     = 3'b011;
    localparam logic [2:0] OP_CLEAR     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } lif_state_t;

    // Replicated across the whole weight word: every synapse starts at +1.
    localparam logic        WEIGHT_INIT    = 1'b1;
    localparam int unsigned THRESHOLD_INIT = 5;

endpackage
`default_nettype wire

// File: rtl/lif_update.sv
`default_nettype none
// ============================================================================
//  Module   : lif_update
//  Purpose  : Combinational single-neuron step: binary-weight sum, shift leak,
//             saturation, threshold compare and reset-by-subtraction.
//  Revision : 1.0  initial release
// ============================================================================
module lif_update #(
    parameter int N_INPUTS       = 32,
    parameter int MEMBRANE_BITS  = 8,
    parameter int THRESHOLD_BITS = 6,
    parameter int SHIFT_BITS     = 3
) (
    input  logic [N_INPUTS-1:0]             inputs,
    input  logic [N_INPUTS-1:0]             weight,
    input  logic signed [MEMBRANE_BITS-1:0] membrane,
    input  logic [THRESHOLD_BITS-1:0]       threshold,
    input  logic [SHIFT_BITS-1:0]           shift,
    output logic signed [MEMBRANE_BITS-1:0] membrane_next,
    output logic                            spike
);

    localparam int SUM_W = $clog2(N_INPUTS) + 2;
    // Two guard bits over the wider of membrane and sum so the add can never wrap.
    localparam int EXT_W = ((MEMBRANE_BITS > SUM_W) ? MEMBRANE_BITS : SUM_W) + 2;
    localparam logic signed [EXT_W-1:0] c_mem_max = EXT_W'((1 << (MEMBRANE_BITS - 1)) - 1);
    localparam logic signed [EXT_W-1:0] c_mem_min = EXT_W'(-(1 << (MEMBRANE_BITS - 1)));

    logic [SUM_W-1:0]                w_pos;
    logic [SUM_W-1:0]                w_neg;
    logic signed [SUM_W-1:0]         w_sum;
    logic signed [MEMBRANE_BITS-1:0] w_leak;
    logic signed [EXT_W-1:0]         w_m1;
    logic signed [EXT_W-1:0]         w_sat;
    logic signed [EXT_W-1:0]         w_thr;
    logic signed [EXT_W-1:0]         w_diff;

    always_comb begin
        w_pos = '0;
        w_neg = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            w_pos = w_pos + SUM_W'(inputs[i] & weight[i]);
            w_neg = w_neg + SUM_W'(inputs[i] & ~weight[i]);
        end
    end

    assign w_sum = signed'(w_pos - w_neg);

    // A zero shift means "no leak", not "leak the whole membrane".
    always_comb begin
        w_leak = '0;
        if (shift != '0) begin
            w_leak = membrane >>> shift;
        end
    end

    assign w_m1 = EXT_W'(membrane) - EXT_W'(w_leak) + EXT_W'(w_sum);

    always_comb begin
        if (w_m1 > c_mem_max) begin
            w_sat = c_mem_max;
        end else if (w_m1 < c_mem_min) begin
            w_sat = c_mem_min;
        end else begin
            w_sat = w_m1;
        end
    end

    assign w_thr         = signed'(EXT_W'(threshold));
    assign spike         = (w_sat >= w_thr);
    assign w_diff        = w_sat - w_thr;
    assign membrane_next = spike ? MEMBRANE_BITS'(w_diff) : MEMBRANE_BITS'(w_sat);

endmodule
`default_nettype wire

// File: rtl/lif_layer_tdm.sv
`default_nettype none
// ============================================================================
//  Module   : lif_layer_tdm
//  Purpose  : Layer of LIF neurons sharing one update datapath, one neuron per
//             cycle, configured over a byte-wide setup bus.
//  Revision : 1.0  initial release
// ============================================================================
module lif_layer_tdm
    import lif_pkg::*;
#(
    parameter int N_INPUTS       = 32,
    parameter int N_NEURONS      = 4,
    parameter int MEMBRANE_BITS  = 8,
    parameter int THRESHOLD_BITS = 6,
    parameter int SHIFT_BITS     = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       data_in,
    input  logic [2:0]                       setup_control,
    input  logic                             setup_valid,
    input  logic [$clog2(N_NEURONS)-1:0]     neuron_sel,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [N_NEURONS-1:0]             spikes,
    output logic signed [MEMBRANE_BITS-1:0]  membrane_out
);

    localparam int SEL_W = $clog2(N_NEURONS);

    lif_state_t                      r_state;
    logic [N_INPUTS-1:0]             r_inputs;
    logic [N_INPUTS-1:0]             r_weights [N_NEURONS];
    logic [THRESHOLD_BITS-1:0]       r_thresh  [N_NEURONS];
    logic signed [MEMBRANE_BITS-1:0] r_mem     [N_NEURONS];
    logic [SHIFT_BITS-1:0]           r_shift;
    logic [SEL_W-1:0]                r_idx;
    logic [N_NEURONS-1:0]            r_spk_acc;

    logic                            w_sel_ok;
    logic [N_INPUTS-1:0]             w_inputs_shifted;
    logic [N_INPUTS-1:0]             w_weight_shifted;
    logic signed [MEMBRANE_BITS-1:0] w_mem_next;
    logic                            w_spike;

    assign w_sel_ok = (32'(neuron_sel) < N_NEURONS);

    generate
        if (N_INPUTS > 8) begin : g_shift_wide
            assign w_inputs_shifted = {r_inputs[N_INPUTS-9:0], data_in};
            assign w_weight_shifted = {r_weights[neuron_sel][N_INPUTS-9:0], data_in};
        end else begin : g_shift_byte
            assign w_inputs_shifted = data_in;
            assign w_weight_shifted = data_in;
        end
    endgenerate

    lif_update #(
        .N_INPUTS       (N_INPUTS),
        .MEMBRANE_BITS  (MEMBRANE_BITS),
        .THRESHOLD_BITS (THRESHOLD_BITS),
        .SHIFT_BITS     (SHIFT_BITS)
    ) u_update (
        .inputs        (r_inputs),
        .weight        (r_weights[r_idx]),
        .membrane      (r_mem[r_idx]),
        .threshold     (r_thresh[r_idx]),
        .shift         (r_shift),
        .membrane_next (w_mem_next),
        .spike         (w_spike)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_inputs     <= '0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_spk_acc    <= '0;
            for (int n = 0; n < N_NEURONS; n++) begin
                r_weights[n] <= {N_INPUTS{WEIGHT_INIT}};
                r_thresh[n]  <= THRESHOLD_BITS'(THRESHOLD_INIT);
                r_mem[n]     <= '0;
            end
            spikes       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            membrane_out <= '0;
        end else begin
            done         <= 1'b0;
            membrane_out <= r_mem[neuron_sel];
            case (r_state)
                ST_IDLE: begin
                    // start takes priority over a setup write in the same cycle
                    if (start) begin
                        r_state <= ST_COMPUTE;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                    end else if (setup_valid) begin
                        case (setup_control)
                            OP_INPUTS:    r_inputs <= w_inputs_shifted;
                            OP_WEIGHTS:   if (w_sel_ok) r_weights[neuron_sel] <= w_weight_shifted;
                            OP_THRESHOLD: if (w_sel_ok) r_thresh[neuron_sel] <= data_in[THRESHOLD_BITS-1:0];
                            OP_SHIFT:     r_shift <= data_in[SHIFT_BITS-1:0];
                            OP_CLEAR: begin
                                for (int n = 0; n < N_NEURONS; n++) begin
                                    r_mem[n] <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_COMPUTE: begin
                    r_mem[r_idx]     <= w_mem_next;
                    r_spk_acc[r_idx] <= w_spike;
                    if (r_idx == SEL_W'(N_NEURONS - 1)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    spikes  <= r_spk_acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lif_layer_tdm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lif_layer_tdm
//  Purpose  : Self-checking bench for lif_layer_tdm against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lif_layer_tdm;

    localparam int N_IN  = 32;
    localparam int N_NEU = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        data_in;
    logic [2:0]        setup_control;
    logic              setup_valid;
    logic [1:0]        neuron_sel;
    logic              start;
    logic              busy;
    logic              done;
    logic [N_NEU-1:0]  spikes;
    logic signed [7:0] membrane_out;

    lif_layer_tdm #(
        .N_INPUTS       (N_IN),
        .N_NEURONS      (N_NEU),
        .MEMBRANE_BITS  (8),
        .THRESHOLD_BITS (6),
        .SHIFT_BITS     (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .setup_control (setup_control),
        .setup_valid   (setup_valid),
        .neuron_sel    (neuron_sel),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .spikes        (spikes),
        .membrane_out  (membrane_out)
    );

    always #5 clk = ~clk;

    // Model: expected register contents and outputs for the current cycle.
    logic [N_IN-1:0] m_inputs;
    logic [N_IN-1:0] m_weights [N_NEU];
    int              m_thr     [N_NEU];
    int              m_mem     [N_NEU];
    int              m_shift;
    int              m_busy, m_done, m_spikes, m_mo;
    bit              chk_en;
    int              n_checks, n_pass;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",         int'(busy),         m_busy);
            check("done",         int'(done),         m_done);
            check("spikes",       int'(spikes),       m_spikes);
            check("membrane_out", int'(membrane_out), m_mo);
        end
    end

    function automatic void model_reset();
        m_inputs = '0;
        m_shift  = 0;
        for (int n = 0; n < N_NEU; n++) begin
            m_weights[n] = '1;
            m_thr[n]     = 5;
            m_mem[n]     = 0;
        end
        m_busy = 0; m_done = 0; m_spikes = 0; m_mo = 0;
    endfunction

    function automatic void model_neuron(input int n, output int mnew, output int spk);
        int sum = 0;
        int leak;
        int m1;
        for (int b = 0; b < N_IN; b++)
            if (m_inputs[b]) sum += m_weights[n][b] ? 1 : -1;
        leak = (m_shift == 0) ? 0 : (m_mem[n] >>> m_shift);
        m1 = m_mem[n] - leak + sum;
        if (m1 > 127)  m1 = 127;
        if (m1 < -128) m1 = -128;
        if (m1 >= m_thr[n]) begin spk = 1; mnew = m1 - m_thr[n]; end
        else                begin spk = 0; mnew = m1;             end
    endfunction

    // One clock edge; membrane_out picks up whatever was stored before it.
    task automatic cycle();
        int pre;
        pre = m_mem[neuron_sel];
        @(posedge clk);
        #2;
        m_mo = pre;
    endtask

    task automatic setup(input int op, input int sel, input int data);
        setup_valid   = 1'b1;
        setup_control = op[2:0];
        neuron_sel    = sel[1:0];
        data_in       = data[7:0];
        cycle();
        setup_valid = 1'b0;
        case (op)
            0: m_inputs = {m_inputs[N_IN-9:0], data[7:0]};
            1: m_weights[sel] = {m_weights[sel][N_IN-9:0], data[7:0]};
            2: m_thr[sel] = data & 63;
            3: m_shift = data & 7;
            7: for (int n = 0; n < N_NEU; n++) m_mem[n] = 0;
            default: ;
        endcase
    endtask

    task automatic timestep(input bit intf, input bit setup_too);
        int res_mem [N_NEU];
        int res_spk;
        int spk;
        start = 1'b1;
        if (setup_too) begin
            setup_valid   = 1'b1;
            setup_control = 3'($urandom_range(0, 7));
            data_in       = 8'($urandom_range(0, 255));
        end
        cycle();
        start = 1'b0;
        setup_valid = 1'b0;
        m_busy = 1;
        res_spk = 0;
        for (int n = 0; n < N_NEU; n++) begin
            model_neuron(n, res_mem[n], spk);
            res_spk |= spk << n;
        end
        for (int i = 0; i < N_NEU; i++) begin
            if (intf) begin
                start         = 1'b1;
                setup_valid   = 1'b1;
                setup_control = 3'b001;
                neuron_sel    = 2'(i);
                data_in       = 8'h00;
            end
            cycle();
            m_mem[i] = res_mem[i];
        end
        start = 1'b0;
        setup_valid = 1'b0;
        cycle();
        m_busy = 0; m_done = 1; m_spikes = res_spk;
        cycle();
        m_done = 0;
    endtask

    task automatic read_mem(input int sel, input int exp_lit, input string name);
        neuron_sel = sel[1:0];
        cycle();
        check(name, int'(membrane_out), exp_lit);
    endtask

    initial begin
        rst_n = 1'b0; data_in = '0; setup_control = '0; setup_valid = 1'b0;
        neuron_sel = '0; start = 1'b0;
        n_checks = 0; n_pass = 0; chk_en = 1'b0;
        model_reset();
        #1 chk_en = 1'b1;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();

        // All-ones inputs with default +1 weights: +32 per step, threshold 5.
        repeat (4) setup(0, 0, 255);
        timestep(0, 0);
        check("lit_spikes_all", int'(spikes), 15);
        for (int i = 0; i < N_NEU; i++) read_mem(i, 27, "lit_mem_27");
        timestep(0, 0);
        check("lit_spikes_all2", int'(spikes), 15);
        read_mem(0, 54, "lit_mem_54");

        // Neuron 2 all -1 weights: walks down and saturates at -128.
        setup(7, 0, 0);
        repeat (4) setup(1, 2, 0);
        repeat (5) begin
            timestep(0, 0);
            check("lit_spike_bit2", int'(spikes[2]), 0);
        end
        read_mem(2, -128, "lit_saturate");

        // Leak by shift with no input drive.
        setup(7, 0, 0);
        repeat (4) setup(1, 2, 255);
        timestep(0, 0);
        for (int n = 0; n < N_NEU; n++) setup(2, n, 63);
        repeat (4) setup(0, 0, 0);
        setup(3, 0, 1);
        timestep(0, 0);
        check("lit_leak_spikes", int'(spikes), 0);
        read_mem(0, 14, "lit_leak_14");
        setup(3, 0, 0);
        timestep(0, 0);
        read_mem(3, 14, "lit_noleak_14");

        // Neuron 1 at threshold 63 fires on the second step.
        setup(7, 0, 0);
        setup(2, 0, 5); setup(2, 2, 5); setup(2, 3, 5);
        repeat (4) setup(0, 0, 255);
        timestep(0, 0);
        check("lit_thr_step1", int'(spikes), 13);
        timestep(0, 0);
        check("lit_thr_step2", int'(spikes), 15);
        read_mem(1, 1, "lit_thr_sub");

        // start/setup while busy are ignored; next step proves weights intact.
        timestep(1, 0);
        timestep(0, 0);

        // Asynchronous reset in the middle of a timestep.
        neuron_sel = 2'd3;
        start = 1'b1;
        cycle();
        start = 1'b0;
        m_busy = 1;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check("rst_busy",   int'(busy),         0);
        check("rst_done",   int'(done),         0);
        check("rst_spikes", int'(spikes),       0);
        check("rst_mem",    int'(membrane_out), 0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        repeat (4) setup(0, 0, 255);
        timestep(0, 0);
        read_mem(0, 27, "lit_post_rst_27");
        setup(7, 0, 0);
        cycle();
        check("lit_clear", int'(membrane_out), 0);

        // Randomised traffic checked cycle-by-cycle against the model.
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 5))
                0, 1: setup(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 255)));
                2:    setup(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 255)));
                3, 4: timestep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: begin
                    neuron_sel = 2'($urandom_range(0, 3));
                    cycle();
                end
            endcase
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
